// File: rtl/uart_mem_pkg.sv
// rtl/uart_mem_pkg.sv - opcodes, response bytes and FSM encoding shared by the UART memory command sequencer
package uart_mem_pkg;

    localparam logic [7:0] OP_PING     = 8'h50;
    localparam logic [7:0] OP_WRITE    = 8'h57;
    localparam logic [7:0] OP_READ     = 8'h52;
    localparam logic [7:0] ACK_DEFAULT = 8'h4B;
    localparam logic [7:0] NAK_DEFAULT = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        LEN,
        WDATA,
        RD_ISSUE,
        RD_WAIT,
        TX_SEND
    } state_t;

endpackage

// File: rtl/uart_mem_timeout.sv
// rtl/uart_mem_timeout.sv - loadable down-counter flagging an inter-byte gap of TIMEOUT_CYC cycles
module uart_mem_timeout #(
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned     W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0]    LOAD = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (enable && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A byte arriving in the same cycle as expiry wins, so the command is not aborted.
    assign expired = enable && !clear && (cnt == '0);

endmodule

// File: rtl/uart_mem_cmd_ctrl.sv
// rtl/uart_mem_cmd_ctrl.sv - host byte-command sequencer between UART rx/tx and one 8-bit BRAM port
module uart_mem_cmd_ctrl
    import uart_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 11,
    parameter int unsigned TIMEOUT_CYC = 200000,
    parameter logic [7:0]  ACK_BYTE    = ACK_DEFAULT,
    parameter logic [7:0]  NAK_BYTE    = NAK_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_we,
    input  logic              tx_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    state_t            state, state_d;
    logic [ADDR_W-1:0] addr, addr_d, mem_addr_d;
    logic [7:0]        addr_hi, addr_hi_d, count, count_d;
    logic [7:0]        tx_data_d, mem_wdata_d;
    logic              is_read, is_read_d;
    logic              tx_we_d, mem_we_d, mem_re_d, cmd_err_d, busy_d;
    logic              timed, to_expired;

    assign timed = (state == ADDR_HI) || (state == ADDR_LO) || (state == LEN) || (state == WDATA);

    uart_mem_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (rx_valid || !timed),
        .enable  (timed),
        .expired (to_expired)
    );

    always_comb begin
        state_d     = state;
        addr_d      = addr;
        addr_hi_d   = addr_hi;
        count_d     = count;
        is_read_d   = is_read;
        tx_data_d   = tx_data;
        tx_we_d     = tx_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        cmd_err_d   = 1'b0;

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    is_read_d = (rx_data == OP_READ);
                    case (rx_data)
                        OP_WRITE, OP_READ: state_d = ADDR_HI;
                        OP_PING: begin
                            tx_data_d = ACK_BYTE;
                            tx_we_d   = 1'b1;
                            state_d   = TX_SEND;
                        end
                        default: begin
                            tx_data_d = NAK_BYTE;
                            tx_we_d   = 1'b1;
                            state_d   = TX_SEND;
                        end
                    endcase
                end
            end
            ADDR_HI, ADDR_LO, LEN: begin
                if (to_expired) begin
                    state_d   = IDLE;
                    cmd_err_d = 1'b1;
                end else if (rx_valid) begin
                    if (state == ADDR_HI) begin
                        addr_hi_d = rx_data;
                        state_d   = ADDR_LO;
                    end else if (state == ADDR_LO) begin
                        addr_d  = ADDR_W'({addr_hi, rx_data});
                        state_d = LEN;
                    end else begin
                        count_d = rx_data;
                        state_d = is_read ? RD_ISSUE : WDATA;
                    end
                end
            end
            WDATA: begin
                if (to_expired) begin
                    state_d   = IDLE;
                    cmd_err_d = 1'b1;
                end else if (rx_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr;
                    mem_wdata_d = rx_data;
                    addr_d      = addr + 1'b1;
                    if (count == 8'd0) begin
                        tx_data_d = ACK_BYTE;
                        tx_we_d   = 1'b1;
                        state_d   = TX_SEND;
                    end else begin
                        count_d = count - 8'd1;
                    end
                end
            end
            RD_ISSUE: begin
                mem_re_d   = 1'b1;
                mem_addr_d = addr;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                // mem_re is registered, so read data lands the cycle after it drops.
                if (!mem_re) begin
                    tx_data_d = mem_rdata;
                    tx_we_d   = 1'b1;
                    state_d   = TX_SEND;
                end
            end
            TX_SEND: begin
                if (tx_we && !tx_wait) begin
                    tx_we_d = 1'b0;
                    if (is_read && (count != 8'd0)) begin
                        addr_d  = addr + 1'b1;
                        count_d = count - 8'd1;
                        state_d = RD_ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_valid && ((state == RD_ISSUE) || (state == RD_WAIT) || (state == TX_SEND))) begin
            cmd_err_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            addr      <= '0;
            addr_hi   <= '0;
            count     <= '0;
            is_read   <= 1'b0;
            tx_data   <= '0;
            tx_we     <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            busy      <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_d;
            addr      <= addr_d;
            addr_hi   <= addr_hi_d;
            count     <= count_d;
            is_read   <= is_read_d;
            tx_data   <= tx_data_d;
            tx_we     <= tx_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_we    <= mem_we_d;
            mem_re    <= mem_re_d;
            busy      <= busy_d;
            cmd_err   <= cmd_err_d;
        end
    end

endmodule
